// File: rtl/hdmi_pattern_gen.sv
// Parametrised DE/HSYNC/VSYNC timing source driving RGB from four built-in test patterns.
// Run/stop and pattern selection only take effect on frame boundaries; all outputs are registered.
module hdmi_pattern_gen #(
  parameter int   H_RES    = 64,
  parameter int   H_FP     = 8,
  parameter int   H_SYNC   = 2,
  parameter int   H_BP     = 8,
  parameter int   V_RES    = 64,
  parameter int   V_FP     = 8,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 8,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   DW       = 8,
  parameter int   CW       = 11,
  parameter int   CHK_LOG2 = 3
) (
  input  logic          hdmi_clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    mode,
  output logic          hdmi_de,
  output logic          hdmi_hs,
  output logic          hdmi_vs,
  output logic [DW-1:0] hdmi_r,
  output logic [DW-1:0] hdmi_g,
  output logic [DW-1:0] hdmi_b,
  output logic          sof,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOTAL   = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_RES + V_FP + V_SYNC + V_BP;
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  localparam logic [CW-1:0] H_ACT    = CW'(H_RES);
  localparam logic [CW-1:0] H_SS     = CW'(H_RES + H_FP);
  localparam logic [CW-1:0] H_SE     = CW'(H_RES + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT    = CW'(V_RES);
  localparam logic [CW-1:0] V_SS     = CW'(V_RES + V_FP);
  localparam logic [CW-1:0] V_SE     = CW'(V_RES + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] BAR_LAST = CW'(H_RES / 8 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [DW-1:0] DW_ONE   = DW'(1);

  if ((2 ** CW) <= MAX_TOTAL) begin : g_cw_check
    $error("hdmi_pattern_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if ((H_RES % 8) != 0) begin : g_bar_check
    $error("hdmi_pattern_gen: H_RES must be a multiple of 8");
  end
  if ((DW > 16) || (CHK_LOG2 >= CW)) begin : g_width_check
    $error("hdmi_pattern_gen: DW must be <= 16 and CHK_LOG2 < CW");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        r_state;
  logic [CW-1:0] r_hcnt;
  logic [CW-1:0] r_vcnt;
  logic [1:0]    r_mode;
  logic [CW-1:0] r_bar_px;
  logic [2:0]    r_bar_idx;

  logic          w_h_last, w_v_last, w_origin, w_de, w_hs_act, w_vs_act, w_chk;
  logic [DW-1:0] w_x, w_y, w_f, w_r, w_g, w_b;

  assign w_h_last = (r_hcnt == H_LAST);
  assign w_v_last = (r_vcnt == V_LAST);
  assign w_origin = (r_hcnt == {CW{1'b0}}) && (r_vcnt == {CW{1'b0}});
  assign w_de     = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_hs_act = (r_hcnt >= H_SS) && (r_hcnt < H_SE);
  assign w_vs_act = (r_vcnt >= V_SS) && (r_vcnt < V_SE);
  assign w_chk    = r_hcnt[CHK_LOG2] ^ r_vcnt[CHK_LOG2];
  // frame_cnt has already advanced past the current frame everywhere except at its first pixel
  assign w_f      = w_origin ? frame_cnt[DW-1:0] : (frame_cnt[DW-1:0] - DW_ONE);

  if (CW >= DW) begin : g_xy_trunc
    assign w_x = r_hcnt[DW-1:0];
    assign w_y = r_vcnt[DW-1:0];
  end else begin : g_xy_ext
    assign w_x = {{(DW-CW){1'b0}}, r_hcnt};
    assign w_y = {{(DW-CW){1'b0}}, r_vcnt};
  end

  // Pattern colour for the current (pre-edge) pixel position
  always_comb begin
    w_r = {DW{1'b0}};
    w_g = {DW{1'b0}};
    w_b = {DW{1'b0}};
    case (r_mode)
      2'd0: begin
        w_r = {DW{~r_bar_idx[1]}};
        w_g = {DW{~r_bar_idx[2]}};
        w_b = {DW{~r_bar_idx[0]}};
      end
      2'd1: begin
        w_r = w_x;
        w_g = w_x;
        w_b = w_x;
      end
      2'd2: begin
        w_r = {DW{~w_chk}};
        w_g = {DW{~w_chk}};
        w_b = {DW{~w_chk}};
      end
      2'd3: begin
        w_r = w_f;
        w_g = w_x;
        w_b = w_y;
      end
      default: begin
        w_r = {DW{1'b0}};
        w_g = {DW{1'b0}};
        w_b = {DW{1'b0}};
      end
    endcase
  end

  // Run/idle control, raster counters and registered video outputs
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_hcnt    <= {CW{1'b0}};
      r_vcnt    <= {CW{1'b0}};
      r_mode    <= 2'd0;
      r_bar_px  <= {CW{1'b0}};
      r_bar_idx <= 3'd0;
      hdmi_de   <= 1'b0;
      hdmi_hs   <= ~HS_POL;
      hdmi_vs   <= ~VS_POL;
      hdmi_r    <= {DW{1'b0}};
      hdmi_g    <= {DW{1'b0}};
      hdmi_b    <= {DW{1'b0}};
      sof       <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          hdmi_de   <= w_de;
          hdmi_hs   <= w_hs_act ? HS_POL : ~HS_POL;
          hdmi_vs   <= w_vs_act ? VS_POL : ~VS_POL;
          hdmi_r    <= w_de ? w_r : {DW{1'b0}};
          hdmi_g    <= w_de ? w_g : {DW{1'b0}};
          hdmi_b    <= w_de ? w_b : {DW{1'b0}};
          sof       <= w_origin;
          frame_cnt <= w_origin ? (frame_cnt + 16'd1) : frame_cnt;
          if (w_h_last) begin
            r_hcnt    <= {CW{1'b0}};
            r_bar_px  <= {CW{1'b0}};
            r_bar_idx <= 3'd0;
            if (w_v_last) begin
              r_vcnt  <= {CW{1'b0}};
              r_mode  <= mode;
              r_state <= en ? ST_RUN : ST_IDLE;
            end else begin
              r_vcnt  <= r_vcnt + CNT_ONE;
            end
          end else begin
            r_hcnt <= r_hcnt + CNT_ONE;
            if (r_bar_px == BAR_LAST) begin
              r_bar_px  <= {CW{1'b0}};
              r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
              r_bar_px  <= r_bar_px + CNT_ONE;
            end
          end
        end
        default: begin
          r_hcnt    <= {CW{1'b0}};
          r_vcnt    <= {CW{1'b0}};
          r_bar_px  <= {CW{1'b0}};
          r_bar_idx <= 3'd0;
          hdmi_de   <= 1'b0;
          hdmi_hs   <= ~HS_POL;
          hdmi_vs   <= ~VS_POL;
          hdmi_r    <= {DW{1'b0}};
          hdmi_g    <= {DW{1'b0}};
          hdmi_b    <= {DW{1'b0}};
          sof       <= 1'b0;
          frame_cnt <= frame_cnt;
          if (en) begin
            r_state <= ST_RUN;
            r_mode  <= mode;
          end else begin
            r_state <= ST_IDLE;
            r_mode  <= r_mode;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Scoreboard bench for hdmi_pattern_gen: a frame-level reference model queues the expected output
// of every clock edge, and an independent monitor pops and compares each edge's DUT output.
module tb_hdmi_pattern_gen;

  localparam int H_RES  = 64;
  localparam int H_FP   = 8;
  localparam int H_SYNC = 2;
  localparam int H_BP   = 8;
  localparam int V_RES  = 64;
  localparam int V_FP   = 8;
  localparam int V_SYNC = 4;
  localparam int V_BP   = 8;
  localparam int HT     = H_RES + H_FP + H_SYNC + H_BP;
  localparam int VT     = V_RES + V_FP + V_SYNC + V_BP;
  localparam int FT     = HT * VT;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        sof;
    logic [15:0] fc;
  } out_t;

  logic        hdmi_clk = 1'b0;
  logic        rst_n    = 1'b0;
  logic        en       = 1'b0;
  logic [1:0]  mode     = 2'd0;
  logic        hdmi_de, hdmi_hs, hdmi_vs, sof;
  logic [7:0]  hdmi_r, hdmi_g, hdmi_b;
  logic [15:0] frame_cnt;

  hdmi_pattern_gen #(
    .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b1), .VS_POL(1'b1), .DW(8), .CW(11), .CHK_LOG2(3)
  ) dut (
    .hdmi_clk (hdmi_clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .hdmi_de  (hdmi_de),
    .hdmi_hs  (hdmi_hs),
    .hdmi_vs  (hdmi_vs),
    .hdmi_r   (hdmi_r),
    .hdmi_g   (hdmi_g),
    .hdmi_b   (hdmi_b),
    .sof      (sof),
    .frame_cnt(frame_cnt)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state: frame-relative cycle index, not raster counters
  bit m_run    = 1'b0;
  int m_t      = 0;
  int m_mode   = 0;
  int m_frames = 0;
  int m_fidx   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
    end
  endtask

  function automatic out_t cur_out();
    out_t o;
    o.de = hdmi_de; o.hs = hdmi_hs; o.vs = hdmi_vs;
    o.r = hdmi_r; o.g = hdmi_g; o.b = hdmi_b;
    o.sof = sof; o.fc = frame_cnt;
    return o;
  endfunction

  function automatic out_t idle_out();
    out_t o;
    o = '0;
    o.fc = 16'(m_frames);
    return o;
  endfunction

  function automatic out_t pix(input int x, input int y, input int md, input int f);
    out_t o;
    int   bar;
    o     = '0;
    o.de  = (x < H_RES) && (y < V_RES);
    o.hs  = (x >= H_RES + H_FP) && (x < H_RES + H_FP + H_SYNC);
    o.vs  = (y >= V_RES + V_FP) && (y < V_RES + V_FP + V_SYNC);
    o.sof = (x == 0) && (y == 0);
    if (o.de) begin
      case (md)
        0: begin
          bar = x / (H_RES / 8);
          o.r = (((bar >> 1) & 1) != 0) ? 8'h00 : 8'hFF;
          o.g = (((bar >> 2) & 1) != 0) ? 8'h00 : 8'hFF;
          o.b = ((bar & 1) != 0) ? 8'h00 : 8'hFF;
        end
        1: begin
          o.r = 8'(x); o.g = 8'(x); o.b = 8'(x);
        end
        2: begin
          o.r = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 8'h00 : 8'hFF;
          o.g = o.r;
          o.b = o.r;
        end
        3: begin
          o.r = 8'(f); o.g = 8'(x); o.b = 8'(y);
        end
        default: o.r = 8'h00;
      endcase
    end
    return o;
  endfunction

  // advance the model by one edge using the inputs the DUT will sample, queue its output
  task automatic step();
    out_t o;
    if (!rst_n) begin
      m_run = 1'b0; m_t = 0; m_mode = 0; m_frames = 0;
      o = idle_out();
    end else if (!m_run) begin
      o = idle_out();
      if (en) begin
        m_run = 1'b1; m_mode = int'(mode); m_t = 0;
      end
    end else begin
      if (m_t == 0) begin
        m_fidx   = m_frames;
        m_frames = (m_frames + 1) % 65536;
      end
      o    = pix(m_t % HT, m_t / HT, m_mode, m_fidx);
      o.fc = 16'(m_frames);
      m_t++;
      if (m_t == FT) begin
        m_t    = 0;
        m_mode = int'(mode);
        if (!en) m_run = 1'b0;
      end
    end
    exp_q.push_back(o);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      @(negedge hdmi_clk);
    end
  endtask

  // monitor: scoreboard compare plus model-independent frame/sync shape checks
  out_t mon_e, mon_a;
  int   de_cnt = 0;
  bit   de_arm = 1'b0;
  int   hs_run = 0;
  always @(posedge hdmi_clk) begin
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_underrun at %0t: got empty queue, expected an entry", $time);
    end else begin
      mon_e = exp_q.pop_front();
      mon_a = cur_out();
      check("pixel", 64'(mon_a), 64'(mon_e));
    end
    if (!rst_n) begin
      de_arm = 1'b0;
      hs_run = 0;
    end else begin
      if (sof) begin
        if (de_arm) check("de_per_frame", 64'(de_cnt), 64'(H_RES * V_RES));
        de_arm = 1'b1;
        de_cnt = 0;
      end
      if (hdmi_de) de_cnt++;
      if (hdmi_hs) begin
        hs_run++;
      end else begin
        if (hs_run != 0) check("hs_width", 64'(hs_run), 64'(H_SYNC));
        hs_run = 0;
      end
    end
  end

  initial begin
    out_t zero_o;
    zero_o = '0;
    rst_n = 1'b0; en = 1'b1; mode = 2'd0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1 + 10 * HT + 5);
    mode = 2'd2;                       // mid frame 0: frame 1 becomes checker
    cyc(2 * FT + 10 * HT);
    en = 1'b0; mode = 2'd1;            // line 20 of frame 2: stop at frame end
    cyc(FT - 20 * HT + 40);
    mode = 2'd3; en = 1'b1;            // frames 3..5 ramp
    cyc(3 * FT);
    for (int i = 0; i < 2 * FT; i++) begin
      if ($urandom_range(0, 2999) == 0) en = ~en;
      if ($urandom_range(0, 999) == 0) mode = 2'($urandom_range(0, 3));
      cyc(1);
    end
    en = 1'b1; mode = 2'd1;
    #2 rst_n = 1'b0;
    #1 check("async_reset_run", 64'(cur_out()), 64'(zero_o));
    cyc(3);
    rst_n = 1'b1;
    cyc(400);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset_idle", 64'(cur_out()), 64'(zero_o));
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    force dut.frame_cnt = 16'hFFFF;
    m_frames = 65535;
    cyc(2);
    release dut.frame_cnt;
    cyc(1);
    en = 1'b1; mode = 2'd3;
    cyc(2 * HT + 10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
